// File: rtl/spi16_pkg.sv
// spi16_pkg: shared state encoding, word width and a sizing helper for the 16-bit SPI master.
package spi16_pkg;
    localparam int SPI16_WORD_BITS = 16;
    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi16_state_t;
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/spi16_sclk_gen.sv
// spi16_sclk_gen: SCLK phase counter; flags the cycle whose closing edge flips SCLK.
module spi16_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic res_n,
    input  logic en,
    input  logic sclk,
    output logic sclk_rise_next,
    output logic sclk_fall_next
);
    localparam int PW = $clog2(CLK_DIV + 1);
    localparam logic [PW-1:0] PH_LOAD = PW'(CLK_DIV - 1);
    logic [PW-1:0] ph;
    logic wrap;
    assign wrap = en && ph == '0;
    assign sclk_rise_next = wrap && !sclk;
    assign sclk_fall_next = wrap && sclk;
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) ph <= PH_LOAD;
        else ph <= (!en || ph == '0) ? PH_LOAD : ph - 1'b1;
endmodule

// File: rtl/spi16_master.sv
// spi16_master: 16-bit SPI mode 0 master, MSB first, one full-duplex frame per request.
// Define SPI16_MASTER_TRIG_EN to add a synchronised `trig` input that replays the last captured word.
module spi16_master
    import spi16_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_GAP   = 4
) (
    input  logic                       clk,
    input  logic                       res_n,
    input  logic                       start,
    input  logic [SPI16_WORD_BITS-1:0] din,
    input  logic                       MISO,
`ifdef SPI16_MASTER_TRIG_EN
    input  logic                       trig,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [SPI16_WORD_BITS-1:0] dout,
    output logic                       nCS,
    output logic                       SCLK,
    output logic                       MOSI
);
    localparam int W  = SPI16_WORD_BITS;
    localparam int TW = $clog2(max3(CS_SETUP, CS_HOLD, CS_GAP) + 1);
    spi16_state_t state;
    logic [TW-1:0] tmr;
    logic [3:0] bit_cnt;
    logic [W-1:0] tx, rx, word;
    logic go, sclk_rise_next, sclk_fall_next;
`ifdef SPI16_MASTER_TRIG_EN
    logic [2:0] trig_sync;
    logic [W-1:0] din_q;
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            trig_sync <= '0;
            din_q <= '0;
        end else begin
            trig_sync <= {trig_sync[1:0], trig};
            if (start) din_q <= din;
        end
    // trig_sync[1] is the synchronised level, trig_sync[2] its previous value
    assign go = start || (trig_sync[1] && !trig_sync[2]);
    assign word = start ? din : din_q;
`else
    assign go = start;
    assign word = din;
`endif
    spi16_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
        .clk            (clk),
        .res_n          (res_n),
        .en             (state == SHIFT),
        .sclk           (SCLK),
        .sclk_rise_next (sclk_rise_next),
        .sclk_fall_next (sclk_fall_next)
    );
    always_ff @(posedge clk or negedge res_n)
        if (!res_n) begin
            state <= IDLE;
            tmr <= '0;
            bit_cnt <= '0;
            tx <= '0;
            rx <= '0;
            nCS <= 1'b1;
            SCLK <= 1'b0;
            MOSI <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            dout <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (go) begin
                    state <= SETUP;
                    tmr <= TW'(CS_SETUP - 1);
                    bit_cnt <= 4'(W - 1);
                    tx <= word;
                    nCS <= 1'b0;
                    busy <= 1'b1;
                    MOSI <= word[W-1];
                end
                SETUP: if (tmr == '0) state <= SHIFT;
                    else tmr <= tmr - 1'b1;
                SHIFT: begin
                    if (sclk_rise_next) SCLK <= 1'b1;
                    // MISO is sampled at the very end of the high phase for maximum slave tco margin
                    if (sclk_fall_next) begin
                        SCLK <= 1'b0;
                        rx <= {rx[W-2:0], MISO};
                        if (bit_cnt == '0) begin
                            state <= HOLD;
                            tmr <= TW'(CS_HOLD - 1);
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            tx <= {tx[W-2:0], 1'b0};
                            MOSI <= tx[W-2];
                        end
                    end
                end
                HOLD: if (tmr == '0) begin
                    state <= GAP;
                    tmr <= TW'(CS_GAP);
                    nCS <= 1'b1;
                    MOSI <= 1'b0;
                    done <= 1'b1;
                    dout <= rx;
                end else tmr <= tmr - 1'b1;
                GAP: if (tmr == '0) begin
                    state <= IDLE;
                    busy <= 1'b0;
                end else tmr <= tmr - 1'b1;
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_spi16_master.sv
// tb_spi16_master: two parameterisations checked cycle by cycle against a timing-formula model.
module tb_spi16_master;
    logic clk = 1'b0;
    logic res_n = 1'b1;
    logic start_i [2];
    logic [15:0] din_i [2];
    logic miso_i [2];
    logic trig_i [2];
    logic busy_o [2], done_o [2], ncs_o [2], sclk_o [2], mosi_o [2];
    logic [15:0] dout_o [2];
    int cd [2] = '{4, 1};
    int su [2] = '{2, 1};
    int ho [2] = '{2, 1};
    int ga [2] = '{4, 1};
    int n_cmp = 0, n_bad = 0, cyc = 0;
    int acc [2] = '{-1, -1};
    logic [15:0] word_m [2], rx_m [2], dout_m [2];
    logic go;
    logic [15:0] w;
    logic [3:0] th [2];
    logic [15:0] dq [2];
    logic e_busy, e_done, e_ncs, e_sclk, e_mosi;
    int t, u, k, m;
    int mode [2];
    logic [15:0] rword [2], sh [2], mstr [2];
    logic pend [2], lval [2], sclk_p [2], busy_p [2];
    int dly [2], rise_cnt [2], done_cnt [2], done_cyc [2], done_prev [2], brise [2], bfall [2];

    spi16_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2), .CS_GAP(4)) u0 (
        .clk(clk), .res_n(res_n), .start(start_i[0]), .din(din_i[0]), .MISO(miso_i[0]),
`ifdef SPI16_MASTER_TRIG_EN
        .trig(trig_i[0]),
`endif
        .busy(busy_o[0]), .done(done_o[0]), .dout(dout_o[0]), .nCS(ncs_o[0]), .SCLK(sclk_o[0]), .MOSI(mosi_o[0]));
    spi16_master #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) u1 (
        .clk(clk), .res_n(res_n), .start(start_i[1]), .din(din_i[1]), .MISO(miso_i[1]),
`ifdef SPI16_MASTER_TRIG_EN
        .trig(trig_i[1]),
`endif
        .busy(busy_o[1]), .done(done_o[1]), .dout(dout_o[1]), .nCS(ncs_o[1]), .SCLK(sclk_o[1]), .MOSI(mosi_o[1]));

    always #5 clk = ~clk;

    function automatic int dur(input int i);
        return 1 + su[i] + 32 * cd[i] + ho[i];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Model: frame acceptance, then every output is a function of cycles since acceptance.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!res_n) begin
                th[i] = '0;
                dq[i] = '0;
            end else begin
                go = start_i[i];
                w = din_i[i];
`ifdef SPI16_MASTER_TRIG_EN
                if (!go && th[i][2] && !th[i][3]) begin
                    go = 1'b1;
                    w = dq[i];
                end
                if (start_i[i]) dq[i] = din_i[i];
                th[i] = {th[i][2:0], trig_i[i]};
`endif
                if (go && (acc[i] < 0 || cyc - acc[i] >= dur(i) + ga[i] + 1)) begin
                    acc[i] = cyc;
                    word_m[i] = w;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!res_n) begin
                acc[i] = -1;
                dout_m[i] = '0;
                {e_busy, e_done, e_ncs, e_sclk, e_mosi} = 5'b00100;
            end else begin
                t = (acc[i] < 0) ? -1 : cyc - acc[i];
                u = t - 1 - su[i];
                e_busy = t >= 1 && t <= dur(i) + ga[i];
                e_ncs = !(t >= 1 && t <= dur(i) - 1);
                e_done = t == dur(i);
                e_sclk = t >= 1 && u >= 0 && u < 32 * cd[i] && (u / cd[i]) % 2 == 1;
                k = (u < 0) ? 0 : (u >= 32 * cd[i]) ? 15 : u / (2 * cd[i]);
                e_mosi = !e_ncs && word_m[i][15-k];
                m = (t - su[i]) / (2 * cd[i]);
                if (t > su[i] && (t - su[i]) % (2 * cd[i]) == 0 && m <= 16) rx_m[i][16-m] = miso_i[i];
                if (e_done) dout_m[i] = rx_m[i];
            end
            chk($sformatf("u%0d.busy", i), busy_o[i], e_busy);
            chk($sformatf("u%0d.done", i), done_o[i], e_done);
            chk($sformatf("u%0d.nCS", i), ncs_o[i], e_ncs);
            chk($sformatf("u%0d.SCLK", i), sclk_o[i], e_sclk);
            chk($sformatf("u%0d.MOSI", i), mosi_o[i], e_mosi);
            chk($sformatf("u%0d.dout", i), dout_o[i], dout_m[i]);
        end
    end

    // Slave models and event monitor, one step after each rising clock edge.
    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 2; i++) begin
            if (sclk_o[i] && !sclk_p[i]) begin
                rise_cnt[i]++;
                mstr[i] = {mstr[i][14:0], mosi_o[i]};
            end
            if (done_o[i]) begin
                done_cnt[i]++;
                done_prev[i] = done_cyc[i];
                done_cyc[i] = cyc;
            end
            if (busy_o[i] && !busy_p[i]) brise[i] = cyc;
            if (!busy_o[i] && busy_p[i]) bfall[i] = cyc;
            if (mode[i] == 0) begin
                if (ncs_o[i]) sh[i] = rword[i];
                else if (!sclk_o[i] && sclk_p[i]) sh[i] = {sh[i][14:0], 1'b0};
                miso_i[i] = sh[i][15];
            end else if (mode[i] == 1) begin
                if (sclk_o[i] && !sclk_p[i]) begin
                    pend[i] = 1'b1;
                    dly[i] = cd[i] - 1;
                    lval[i] = mosi_o[i];
                end
                if (pend[i]) begin
                    if (dly[i] == 0) begin
                        miso_i[i] = lval[i];
                        pend[i] = 1'b0;
                    end else dly[i]--;
                end
            end else miso_i[i] = 1'($urandom_range(1));
            sclk_p[i] = sclk_o[i];
            busy_p[i] = busy_o[i];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic clr(input int i);
        rise_cnt[i] = 0;
        done_cnt[i] = 0;
    endtask

    task automatic wait_busy(input int i, input logic lvl, input int budget);
        int n;
        n = 0;
        while (busy_o[i] !== lvl && n < budget) begin
            tick();
            n++;
        end
        chk($sformatf("wait_busy%0d", i), busy_o[i], lvl);
    endtask

    task automatic launch(input int i, input logic [15:0] d);
        start_i[i] = 1'b1;
        din_i[i] = d;
        tick();
        start_i[i] = 1'b0;
        din_i[i] = 16'($urandom);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            start_i[i] = 1'b0;
            din_i[i] = '0;
            miso_i[i] = 1'b0;
            trig_i[i] = 1'b0;
            pend[i] = 1'b0;
            sclk_p[i] = 1'b0;
            busy_p[i] = 1'b0;
            rx_m[i] = '0;
            dout_m[i] = '0;
            word_m[i] = '0;
            mstr[i] = '0;
            sh[i] = '0;
            th[i] = '0;
            dq[i] = '0;
            dly[i] = 0;
            done_cyc[i] = 0;
            done_prev[i] = 0;
            brise[i] = 0;
            bfall[i] = 0;
            clr(i);
        end
        mode[0] = 0;
        mode[1] = 2;
        rword[0] = 16'h3C5A;
        rword[1] = 16'h0000;
        #2 res_n = 1'b0;
        ticks(3);
        res_n = 1'b1;
        @(negedge clk);
        chk("rst_nCS", ncs_o[0], 1'b1);
        chk("rst_busy", busy_o[0], 1'b0);
        chk("rst_dout", dout_o[0], 16'h0000);
        tick();
        // Default frame against a mode 0 slave
        launch(0, 16'hA5C3);
        ticks(140);
        chk("t1_rises", rise_cnt[0], 16);
        chk("t1_mosi", mstr[0], 16'hA5C3);
        chk("t1_dout", dout_o[0], 16'h3C5A);
        chk("t1_done_cyc", done_cyc[0] - (brise[0] - 1), 133);
        chk("t1_idle_cyc", bfall[0] - (brise[0] - 1), 138);
        chk("t1_done_cnt", done_cnt[0], 1);
        // Fast instance, start held high over three frames
        clr(1);
        start_i[1] = 1'b1;
        din_i[1] = 16'h0001;
        wait_busy(1, 1'b1, 5);
        din_i[1] = 16'h8000;
        wait_busy(1, 1'b0, 60);
        wait_busy(1, 1'b1, 5);
        din_i[1] = 16'hFFFF;
        wait_busy(1, 1'b0, 60);
        wait_busy(1, 1'b1, 5);
        start_i[1] = 1'b0;
        wait_busy(1, 1'b0, 60);
        chk("t2_done_cnt", done_cnt[1], 3);
        chk("t2_mosi", mstr[1], 16'hFFFF);
        chk("t2_spacing", done_cyc[1] - done_prev[1], 37);
        // start pulses during a frame are ignored
        clr(0);
        rword[0] = 16'hBEEF;
        tick();
        launch(0, 16'h1357);
        for (int r = 2; r <= 170; r++) begin
            start_i[0] = (r == 5 || r == 40 || r == 100);
            din_i[0] = 16'($urandom);
            tick();
        end
        start_i[0] = 1'b0;
        chk("t3_done_cnt", done_cnt[0], 1);
        chk("t3_mosi", mstr[0], 16'h1357);
        chk("t3_dout", dout_o[0], 16'hBEEF);
        // Asynchronous reset in the middle of a frame
        clr(0);
        launch(0, 16'hC0DE);
        ticks(58);
        #2 res_n = 1'b0;
        #1;
        chk("t4_nCS", ncs_o[0], 1'b1);
        chk("t4_SCLK", sclk_o[0], 1'b0);
        chk("t4_MOSI", mosi_o[0], 1'b0);
        chk("t4_busy", busy_o[0], 1'b0);
        chk("t4_dout", dout_o[0], 16'h0000);
        ticks(2);
        res_n = 1'b1;
        ticks(150);
        chk("t4_no_done", done_cnt[0], 0);
        // Loopback slave with tco of CLK_DIV-1 cycles
        mode[0] = 1;
        launch(0, 16'h1234);
        ticks(145);
        chk("t5_loop", dout_o[0], 16'h1234);
        // Random traffic on both instances
        mode[0] = 2;
        for (int r = 0; r < 3000; r++) begin
            for (int i = 0; i < 2; i++) begin
                start_i[i] = ($urandom_range(7) == 0);
                din_i[i] = 16'($urandom);
            end
            tick();
        end
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        ticks(150);
`ifdef SPI16_MASTER_TRIG_EN
        clr(0);
        mode[0] = 0;
        rword[0] = 16'h0000;
        launch(0, 16'h00F0);
        ticks(150);
        chk("t7_f1", mstr[0], 16'h00F0);
        for (int r = 0; r < 400; r++) begin
            trig_i[0] = (r < 3) || (r >= 50 && r < 53) || (r >= 200 && r < 203);
            din_i[0] = 16'($urandom);
            if (r == 180) chk("t7_f2", mstr[0], 16'h00F0);
            tick();
        end
        trig_i[0] = 1'b0;
        chk("t7_f3", mstr[0], 16'h00F0);
        chk("t7_frames", done_cnt[0], 3);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
